// File: rtl/tap_sched_pkg.sv
// Shared types and helpers for the divider tap-select controller.
package tap_sched_pkg;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_t;

  function automatic int tap_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tap_sched_rise.sv
// Registered rising-edge detector: the output is high in the cycle where the input is high
// and the previous sample was low. The previous sample resets to 0.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= d_i;
  end

  assign rise_o = d_i & ~r_prev;

endmodule

// File: rtl/tap_sched.sv
// Divider tap select: manual plus/minus stepping or a ping-pong sweep with a programmable dwell.
// Optional hold-to-repeat in manual mode is enabled by defining TAP_SCHED_AUTOREPEAT_EN.
module tap_sched
  import tap_sched_pkg::*;
#(
  parameter int SIZE        = 24,
  parameter int DWELL_W     = 16,
  parameter int REPEAT_DLY  = 2**20,
  parameter int REPEAT_RATE = 2**18,
  localparam int TW         = tap_width(SIZE)
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               plus_i,
  input  logic               minus_i,
  input  logic               mode_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [TW-1:0]      tap_o,
  output logic               step_o,
  output logic               sweep_o,
  output logic               dir_o
);

  localparam logic [TW-1:0] TAP_MAX = TW'(SIZE);

  state_t             r_state, w_state_nxt;
  logic [TW-1:0]      r_tap, w_tap_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_step;

  logic w_plus_rise, w_minus_rise, w_mode_rise;
  logic w_rep_up, w_rep_dn;
  logic w_up, w_dn, w_term;
  logic [DWELL_W-1:0] w_dwell_m1;

  rise_detect u_rise_plus  (.clk(clk), .rst_n(rst_i), .d_i(plus_i),  .rise_o(w_plus_rise));
  rise_detect u_rise_minus (.clk(clk), .rst_n(rst_i), .d_i(minus_i), .rise_o(w_minus_rise));
  rise_detect u_rise_mode  (.clk(clk), .rst_n(rst_i), .d_i(mode_i),  .rise_o(w_mode_rise));

`ifdef TAP_SCHED_AUTOREPEAT_EN
  logic        r_hold_act;
  logic [31:0] r_hold;
  logic        w_hold, w_rep_fire;

  // Counting starts on the edge where exactly one button becomes held.
  assign w_hold     = (r_state == MANUAL) && !w_mode_rise && (plus_i ^ minus_i);
  assign w_rep_fire = w_hold && r_hold_act && (r_hold == '0);
  assign w_rep_up   = w_rep_fire & plus_i;
  assign w_rep_dn   = w_rep_fire & minus_i;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_hold_act <= 1'b0;
      r_hold     <= '0;
    end else if (!w_hold) begin
      r_hold_act <= 1'b0;
      r_hold     <= '0;
    end else if (!r_hold_act) begin
      r_hold_act <= 1'b1;
      r_hold     <= 32'(REPEAT_DLY - 1);
    end else if (r_hold == '0) begin
      r_hold     <= 32'(REPEAT_RATE - 1);
    end else begin
      r_hold     <= r_hold - 32'd1;
    end
  end
`else
  assign w_rep_up = 1'b0;
  assign w_rep_dn = 1'b0;
`endif

  assign w_dwell_m1 = (dwell_i == '0) ? '0 : dwell_i - 1'b1;
  assign w_term     = (r_cnt >= w_dwell_m1);
  assign w_up       = (w_plus_rise & ~w_minus_rise) | w_rep_up;
  assign w_dn       = (w_minus_rise & ~w_plus_rise) | w_rep_dn;

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MANUAL: begin
        if (w_mode_rise) begin
          w_state_nxt = (r_tap < TAP_MAX) ? SWEEP_UP : SWEEP_DOWN;
          w_cnt_nxt   = '0;
        end else if (w_up && (r_tap != TAP_MAX)) begin
          w_tap_nxt = r_tap + 1'b1;
        end else if (w_dn && (r_tap != '0)) begin
          w_tap_nxt = r_tap - 1'b1;
        end
      end
      SWEEP_UP: begin
        if (w_mode_rise) begin
          w_state_nxt = MANUAL;
          w_cnt_nxt   = '0;
        end else if (w_term) begin
          w_cnt_nxt = '0;
          // At the top endpoint the turn-around step is taken immediately.
          if (r_tap == TAP_MAX) begin
            w_tap_nxt   = TAP_MAX - 1'b1;
            w_state_nxt = SWEEP_DOWN;
          end else begin
            w_tap_nxt = r_tap + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      SWEEP_DOWN: begin
        if (w_mode_rise) begin
          w_state_nxt = MANUAL;
          w_cnt_nxt   = '0;
        end else if (w_term) begin
          w_cnt_nxt = '0;
          if (r_tap == '0) begin
            w_tap_nxt   = TW'(1);
            w_state_nxt = SWEEP_UP;
          end else begin
            w_tap_nxt = r_tap - 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = MANUAL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= MANUAL;
      r_tap   <= '0;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tap   <= w_tap_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= (w_tap_nxt != r_tap);
    end
  end

  assign tap_o   = r_tap;
  assign step_o  = r_step;
  assign sweep_o = (r_state != MANUAL);
  assign dir_o   = (r_state == SWEEP_UP);

endmodule

// File: tb/tb_tap_sched.sv
// Directed bench for tap_sched with SIZE=4, DWELL_W=4.
module tb_tap_sched;

  logic       clk;
  logic       rst_i;
  logic       plus_i, minus_i, mode_i;
  logic [3:0] dwell_i;
  logic [2:0] tap_o;
  logic       step_o, sweep_o, dir_o;

  int n_tests = 0;
  int n_fail  = 0;

  tap_sched #(.SIZE(4), .DWELL_W(4), .REPEAT_DLY(10), .REPEAT_RATE(4)) dut (
    .clk(clk), .rst_i(rst_i), .plus_i(plus_i), .minus_i(minus_i), .mode_i(mode_i),
    .dwell_i(dwell_i), .tap_o(tap_o), .step_o(step_o), .sweep_o(sweep_o), .dir_o(dir_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Manual button pulse four cycles wide followed by one idle cycle.
  task automatic pulse(input logic p, input logic m, input int exp_tap, input int exp_step,
                       input string tag);
    plus_i = p; minus_i = m;
    tick();
    chk({tag, "_tap"},  32'(tap_o),  32'(exp_tap));
    chk({tag, "_step"}, 32'(step_o), 32'(exp_step));
    repeat (3) tick();
    chk({tag, "_hold_tap"},  32'(tap_o),  32'(exp_tap));
    chk({tag, "_hold_step"}, 32'(step_o), 32'd0);
    plus_i = 1'b0; minus_i = 1'b0;
    tick();
  endtask

  int sweep_tap [7] = '{3, 4, 3, 2, 1, 0, 1};
  int sweep_dir [7] = '{1, 1, 0, 0, 0, 0, 1};

  initial begin
    rst_i = 1'b0; plus_i = 1'b0; minus_i = 1'b0; mode_i = 1'b0; dwell_i = 4'd3;
    #12;
    chk("rst_tap",   32'(tap_o),   32'd0);
    chk("rst_step",  32'(step_o),  32'd0);
    chk("rst_sweep", 32'(sweep_o), 32'd0);
    chk("rst_dir",   32'(dir_o),   32'd0);
    rst_i = 1'b1;
    tick();

    pulse(1'b1, 1'b0, 1, 1, "plus1");
    pulse(1'b1, 1'b0, 2, 1, "plus2");
    pulse(1'b1, 1'b0, 3, 1, "plus3");
    pulse(1'b1, 1'b0, 4, 1, "plus4");
    pulse(1'b1, 1'b0, 4, 0, "plus_sat");

    pulse(1'b0, 1'b1, 3, 1, "minus1");
    pulse(1'b0, 1'b1, 2, 1, "minus2");
    pulse(1'b0, 1'b1, 1, 1, "minus3");
    pulse(1'b0, 1'b1, 0, 1, "minus4");
    pulse(1'b0, 1'b1, 0, 0, "minus_sat");

    pulse(1'b1, 1'b0, 1, 1, "plus5");
    pulse(1'b1, 1'b0, 2, 1, "plus6");
    pulse(1'b1, 1'b1, 2, 0, "both");

    // Sweep from tap 2 with dwell 3.
    mode_i = 1'b1;
    tick();
    mode_i = 1'b0;
    chk("entry_sweep", 32'(sweep_o), 32'd1);
    chk("entry_dir",   32'(dir_o),   32'd1);
    chk("entry_tap",   32'(tap_o),   32'd2);
    for (int i = 0; i < 7; i++) begin
      tick(); tick();
      chk($sformatf("sw%0d_wait_step", i), 32'(step_o), 32'd0);
      tick();
      chk($sformatf("sw%0d_tap", i),  32'(tap_o),  32'(sweep_tap[i]));
      chk($sformatf("sw%0d_step", i), 32'(step_o), 32'd1);
      chk($sformatf("sw%0d_dir", i),  32'(dir_o),  32'(sweep_dir[i]));
    end

    // Lower dwell from 8 to 2 with the counter at 5.
    dwell_i = 4'd8;
    repeat (5) tick();
    chk("dw_before_tap", 32'(tap_o), 32'd1);
    dwell_i = 4'd2;
    tick();
    chk("dw_fire_tap",  32'(tap_o),  32'd2);
    chk("dw_fire_step", 32'(step_o), 32'd1);
    tick();
    chk("dw_mid_tap",   32'(tap_o),  32'd2);
    chk("dw_mid_step",  32'(step_o), 32'd0);
    tick();
    chk("dw_next_tap",  32'(tap_o),  32'd3);
    chk("dw_next_step", 32'(step_o), 32'd1);

    // Mode together with plus: back to manual, plus discarded.
    mode_i = 1'b1; plus_i = 1'b1;
    tick();
    chk("exit_sweep", 32'(sweep_o), 32'd0);
    chk("exit_dir",   32'(dir_o),   32'd0);
    chk("exit_tap",   32'(tap_o),   32'd3);
    mode_i = 1'b0; plus_i = 1'b0;
    tick();
    chk("exit_step",  32'(step_o),  32'd0);
    chk("exit_tap2",  32'(tap_o),   32'd3);

    // Asynchronous reset in the middle of a dwell.
    mode_i = 1'b1;
    tick();
    mode_i = 1'b0;
    chk("re_sweep", 32'(sweep_o), 32'd1);
    tick();
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst_tap",   32'(tap_o),   32'd0);
    chk("arst_step",  32'(step_o),  32'd0);
    chk("arst_sweep", 32'(sweep_o), 32'd0);
    chk("arst_dir",   32'(dir_o),   32'd0);
    mode_i = 1'b1;
    #2;
    rst_i = 1'b1;
    tick();
    chk("rel_sweep", 32'(sweep_o), 32'd1);
    chk("rel_dir",   32'(dir_o),   32'd1);
    chk("rel_step",  32'(step_o),  32'd0);
    tick(); tick();
    chk("rel_tap", 32'(tap_o), 32'd1);
    mode_i = 1'b0;

    // Fresh reset for the held-button scenario.
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
    tick();
    plus_i = 1'b1;
`ifdef TAP_SCHED_AUTOREPEAT_EN
    begin
      int exp_tap;
      exp_tap = 0;
      for (int c = 0; c < 26; c++) begin
        logic exp_step;
        tick();
        exp_step = 1'b0;
        if (c == 0 || c == 10 || c == 14 || c == 18) begin
          exp_tap  = exp_tap + 1;
          exp_step = 1'b1;
        end
        chk($sformatf("rep%0d_tap", c),  32'(tap_o),  32'(exp_tap));
        chk($sformatf("rep%0d_step", c), 32'(step_o), 32'(exp_step));
      end
    end
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("held%0d_tap", c),  32'(tap_o),  32'd1);
      chk($sformatf("held%0d_step", c), 32'(step_o), (c == 0) ? 32'd1 : 32'd0);
    end
`endif
    plus_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
